// File: rtl/ioblock_par.sv
// Configurable bidirectional I/O channels loaded through a daisy-chained serial config chain.
// Drive and readback paths are either combinational or 1-cycle registered; there is no flow control.
module ioblock_par #(
    parameter int WIDTH = 4
) (
    input  logic             IOCLK,
    input  logic             RSTN,
    inout  wire  [WIDTH-1:0] PIN,
    input  logic [WIDTH-1:0] TS,
    input  logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] IN,
    input  logic             CFG_EN,
    input  logic             CFG_DI,
    input  logic             CFG_UPD,
    output logic             CFG_DO
);

    localparam int CFGW = 4 * WIDTH;

    logic [CFGW-1:0]  sr;
    logic [CFGW-1:0]  ac;
    logic [WIDTH-1:0] odr;
    logic [WIDTH-1:0] tsr;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] od;
    logic [WIDTH-1:0] et;
    logic [WIDTH-1:0] de;

    // AC captures the pre-shift SR when update and shift share an edge.
    always_ff @(posedge IOCLK) begin
        if (!RSTN) begin
            sr  <= '0;
            ac  <= '0;
            odr <= '0;
            tsr <= '0;
            d   <= '0;
        end else begin
            if (CFG_EN) begin
                sr <= {sr[CFGW-2:0], CFG_DI};
            end
            if (CFG_UPD) begin
                ac <= sr;
            end
            odr <= OUT;
            tsr <= TS;
            d   <= PIN;
        end
    end

    assign CFG_DO = sr[CFGW-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic       oreg;
        logic       dorreg;
        logic [1:0] tsmux;

        assign oreg   = ac[4*i+3];
        assign dorreg = ac[4*i+2];
        assign tsmux  = ac[4*i+1 -: 2];

        assign od[i] = oreg ? odr[i] : OUT[i];
        assign et[i] = oreg ? tsr[i] : TS[i];

        // Pads float while the chain is shifting so partial configs never drive.
        assign de[i] = !CFG_EN && ((tsmux == 2'b11) ||
                                   (tsmux == 2'b01 &&  et[i]) ||
                                   (tsmux == 2'b10 && !et[i]));

        assign PIN[i] = de[i] ? od[i] : 1'bz;
        assign IN[i]  = dorreg ? d[i] : PIN[i];
    end

endmodule

// File: tb/tb_ioblock_par.sv
// Directed self-checking bench for ioblock_par (WIDTH=4); pads carry a pulldown so high-Z reads as 0.
module tb_ioblock_par;

    localparam int W = 4;

    logic         IOCLK = 1'b0;
    logic         RSTN;
    tri0  [W-1:0] pin;
    logic [W-1:0] TS;
    logic [W-1:0] OUT;
    logic [W-1:0] IN;
    logic         CFG_EN;
    logic         CFG_DI;
    logic         CFG_UPD;
    logic         CFG_DO;
    logic         ext_en;
    logic         ext_val;

    int checks = 0;
    int errors = 0;

    assign pin[3] = ext_en ? ext_val : 1'bz;

    ioblock_par #(.WIDTH(W)) dut (
        .IOCLK   (IOCLK),
        .RSTN    (RSTN),
        .PIN     (pin),
        .TS      (TS),
        .OUT     (OUT),
        .IN      (IN),
        .CFG_EN  (CFG_EN),
        .CFG_DI  (CFG_DI),
        .CFG_UPD (CFG_UPD),
        .CFG_DO  (CFG_DO)
    );

    always #5 IOCLK = ~IOCLK;

    task automatic load(input logic [15:0] p);
        for (int b = 15; b >= 0; b--) begin
            @(negedge IOCLK);
            CFG_EN = 1'b1;
            CFG_DI = p[b];
        end
        @(negedge IOCLK);
        CFG_EN  = 1'b0;
        CFG_UPD = 1'b1;
        @(negedge IOCLK);
        CFG_UPD = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        RSTN = 1'b0; OUT = 4'hF; TS = 4'hF;
        CFG_EN = 1'b0; CFG_DI = 1'b0; CFG_UPD = 1'b0;
        ext_en = 1'b0; ext_val = 1'b0;
        repeat (2) @(negedge IOCLK);
        #1;
        checks++; if (CFG_DO !== 1'b0) begin errors++; $display("FAIL reset_cfg_do: got %b want 0", CFG_DO); end
        checks++; if (pin !== 4'b0000) begin errors++; $display("FAIL reset_pin: got %b want 0000", pin); end
        checks++; if (IN !== 4'b0000) begin errors++; $display("FAIL reset_in: got %b want 0000", IN); end
        RSTN = 1'b1;
    endtask

    task automatic test_ch0_comb();
        load(16'h0003);
        OUT = 4'hF; #1;
        checks++; if (pin !== 4'b0001) begin errors++; $display("FAIL ch0_drive1: got %b want 0001", pin); end
        checks++; if (IN !== 4'b0001) begin errors++; $display("FAIL ch0_readback: got %b want 0001", IN); end
        OUT = 4'b1110; #1;
        checks++; if (pin !== 4'b0000) begin errors++; $display("FAIL ch0_drive0: got %b want 0000", pin); end
    endtask

    task automatic test_tsmux();
        load(16'h0010);
        OUT = 4'hF; TS = 4'hF; #1;
        checks++; if (pin !== 4'b0010) begin errors++; $display("FAIL tsmux01_ts1: got %b want 0010", pin); end
        TS = 4'b1101; #1;
        checks++; if (pin !== 4'b0000) begin errors++; $display("FAIL tsmux01_ts0: got %b want 0000", pin); end
        load(16'h0020);
        TS = 4'hF; #1;
        checks++; if (pin !== 4'b0000) begin errors++; $display("FAIL tsmux10_ts1: got %b want 0000", pin); end
        TS = 4'b1101; #1;
        checks++; if (pin !== 4'b0010) begin errors++; $display("FAIL tsmux10_ts0: got %b want 0010", pin); end
        TS = 4'hF;
    endtask

    task automatic test_oreg();
        load(16'h0B00);
        OUT = 4'b0000;
        @(negedge IOCLK); #1;
        checks++; if (pin !== 4'b0000) begin errors++; $display("FAIL oreg_idle: got %b want 0000", pin); end
        OUT = 4'b0100; #1;
        checks++; if (pin !== 4'b0000) begin errors++; $display("FAIL oreg_before_edge: got %b want 0000", pin); end
        @(posedge IOCLK); #1;
        checks++; if (pin !== 4'b0100) begin errors++; $display("FAIL oreg_after_edge: got %b want 0100", pin); end
        checks++; if (IN !== 4'b0100) begin errors++; $display("FAIL oreg_readback: got %b want 0100", IN); end
    endtask

    task automatic test_dorreg();
        load(16'h4000);
        ext_val = 1'b0; ext_en = 1'b1;
        @(negedge IOCLK);
        ext_val = 1'b1; #1;
        checks++; if (pin[3] !== 1'b1) begin errors++; $display("FAIL dorreg_pad: got %b want 1", pin[3]); end
        checks++; if (IN[3] !== 1'b0) begin errors++; $display("FAIL dorreg_before_edge: got %b want 0", IN[3]); end
        @(posedge IOCLK); #1;
        checks++; if (IN[3] !== 1'b1) begin errors++; $display("FAIL dorreg_after_edge: got %b want 1", IN[3]); end
        @(negedge IOCLK);
        ext_en = 1'b0;
    endtask

    task automatic test_cfg_shift();
        logic [15:0] p;
        p = 16'hB313;
        OUT = 4'hF; TS = 4'hF;
        load(p);
        checks++; if (pin !== 4'b1111) begin errors++; $display("FAIL shift_pre_drive: got %b want 1111", pin); end
        for (int k = 0; k < 16; k++) begin
            @(negedge IOCLK);
            CFG_EN = 1'b1; CFG_DI = 1'b0; #1;
            checks++; if (CFG_DO !== p[15-k]) begin errors++; $display("FAIL shift_do[%0d]: got %b want %b", k, CFG_DO, p[15-k]); end
            checks++; if (pin !== 4'b0000) begin errors++; $display("FAIL shift_hiz[%0d]: got %b want 0000", k, pin); end
        end
        @(negedge IOCLK);
        CFG_EN = 1'b0; #1;
        checks++; if (pin !== 4'b1111) begin errors++; $display("FAIL shift_release: got %b want 1111", pin); end
        checks++; if (CFG_DO !== 1'b0) begin errors++; $display("FAIL shift_drained: got %b want 0", CFG_DO); end
    endtask

    task automatic test_upd_and_reset();
        logic [15:0] p;
        p = 16'h0030;
        OUT = 4'hF; TS = 4'hF;
        load(16'h0003);
        for (int b = 15; b >= 0; b--) begin
            @(negedge IOCLK);
            CFG_EN = 1'b1; CFG_DI = p[b];
        end
        @(negedge IOCLK);
        CFG_EN = 1'b1; CFG_DI = 1'b1; CFG_UPD = 1'b1;
        @(negedge IOCLK);
        CFG_EN = 1'b0; CFG_UPD = 1'b0; #1;
        checks++; if (pin !== 4'b0010) begin errors++; $display("FAIL same_edge_ac: got %b want 0010", pin); end
        @(negedge IOCLK);
        CFG_UPD = 1'b1;
        @(negedge IOCLK);
        CFG_UPD = 1'b0; #1;
        checks++; if (pin !== 4'b0001) begin errors++; $display("FAIL same_edge_sr: got %b want 0001", pin); end
        for (int b = 0; b < 8; b++) begin
            @(negedge IOCLK);
            CFG_EN = 1'b1; CFG_DI = 1'b1;
        end
        @(negedge IOCLK);
        RSTN = 1'b0; CFG_UPD = 1'b1;
        @(negedge IOCLK);
        RSTN = 1'b1; CFG_EN = 1'b0; CFG_UPD = 1'b0; #1;
        checks++; if (CFG_DO !== 1'b0) begin errors++; $display("FAIL midreset_do: got %b want 0", CFG_DO); end
        checks++; if (pin !== 4'b0000) begin errors++; $display("FAIL midreset_pin: got %b want 0000", pin); end
        for (int b = 0; b < 15; b++) begin
            @(negedge IOCLK);
            CFG_EN = 1'b1; CFG_DI = 1'b1;
        end
        @(negedge IOCLK);
        CFG_EN = 1'b0; #1;
        checks++; if (CFG_DO !== 1'b0) begin errors++; $display("FAIL reload_15: got %b want 0", CFG_DO); end
        @(negedge IOCLK);
        CFG_EN = 1'b1; CFG_DI = 1'b1;
        @(negedge IOCLK);
        CFG_EN = 1'b0; #1;
        checks++; if (CFG_DO !== 1'b1) begin errors++; $display("FAIL reload_16: got %b want 1", CFG_DO); end
    endtask

    initial begin
        test_reset();
        test_ch0_comb();
        test_tsmux();
        test_oreg();
        test_dorreg();
        test_cfg_shift();
        test_upd_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
